// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a shared single-cycle-latency memory port
module mem_port_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [15:0] rdata1,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);
  localparam logic       LP_FIXED        = (PRIORITY_MODE != 0);

  logic       r_last_winner;
  logic [7:0] r_starve_cnt;
  logic       r_rvalid0;
  logic       r_rvalid1;

  logic       w_contend;
  logic       w_starved;
  logic       w_gnt0;
  logic       w_gnt1;

  assign w_contend = req0 & req1;
  assign w_starved = (r_starve_cnt == LP_STARVE_LIMIT);

  // Grant decision: a lone requester always wins; contention resolved by mode; no grants in reset
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (w_contend) begin
        if (LP_FIXED) begin
          w_gnt1 = w_starved;
          w_gnt0 = ~w_starved;
        end else begin
          w_gnt0 = r_last_winner;
          w_gnt1 = ~r_last_winner;
        end
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  // Shared port mux: granted requester drives the port, otherwise requester 0 fields with write off
  always_comb begin
    mem_addr  = addr0;
    mem_wdata = wdata0;
    mem_we    = 1'b0;
    if (w_gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end else if (w_gnt0) begin
      mem_we    = we0;
    end
  end

  // Remember who won the last accepted transfer so round-robin contention alternates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_winner <= 1'b1;
    end else if (w_gnt0) begin
      r_last_winner <= 1'b0;
    end else if (w_gnt1) begin
      r_last_winner <= 1'b1;
    end
  end

  // Count cycles requester 1 waits in fixed mode; saturates so the forced grant is guaranteed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 8'd0;
    end else if (!LP_FIXED || !req1 || w_gnt1) begin
      r_starve_cnt <= 8'd0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // Read responses arrive one cycle after acceptance, matching the memory's read latency
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic        fx_gnt0, fx_gnt1, fx_rvalid0, fx_rvalid1, fx_mem_we;
  logic [15:0] fx_rdata0, fx_rdata1, fx_mem_addr, fx_mem_wdata;

  logic [15:0] mem [0:4095];
  logic [7:0]  io_data_in;

  int n_cmp;
  int n_bad;

  mem_port_arbiter #(.PRIORITY_MODE(0), .STARVE_LIMIT(8)) u_rr (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.PRIORITY_MODE(1), .STARVE_LIMIT(3)) u_fx (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(fx_gnt0), .rvalid0(fx_rvalid0), .rdata0(fx_rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(fx_gnt1), .rvalid1(fx_rvalid1), .rdata1(fx_rdata1),
    .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata), .mem_we(fx_mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared memory with one-cycle read latency; address 65533 is an IO input returning its low nibble
  always @(posedge clock) begin
    if (mem_we && mem_addr < 16'd4096) mem[mem_addr[11:0]] <= mem_wdata;
    if (mem_addr == 16'd65533) mem_rdata <= {12'h000, io_data_in[3:0]};
    else                       mem_rdata <= mem[mem_addr[11:0]];
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    io_data_in = 8'hA5;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(16'h1000 + i);
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; wdata0 = 16'h0000;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 16'h0000;
    mem_rdata = 16'h0000;
    repeat (2) tick();

    // Reset: no grants or writes even with both requesting writes
    req0 = 1'b1; we0 = 1'b1; req1 = 1'b1; we1 = 1'b1;
    #1;
    expect_eq("rst_gnt0", gnt0, 0);
    expect_eq("rst_gnt1", gnt1, 0);
    expect_eq("rst_mem_we", mem_we, 0);
    expect_eq("rst_rvalid0", rvalid0, 0);
    expect_eq("rst_rvalid1", rvalid1, 0);
    expect_eq("rst_starve", u_fx.r_starve_cnt, 0);
    tick();
    expect_eq("rst_rvalid0_clk", rvalid0, 0);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick();
    reset = 1'b1;

    // Idle
    #1;
    expect_eq("idle_gnt0", gnt0, 0);
    expect_eq("idle_gnt1", gnt1, 0);
    expect_eq("idle_mem_we", mem_we, 0);
    tick();
    expect_eq("idle_rvalid0", rvalid0, 0);
    expect_eq("idle_rvalid1", rvalid1, 0);
    expect_eq("idle_starve", u_fx.r_starve_cnt, 0);

    // Round-robin contention: grants 0,1,0,1 and responses in the same order
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      #1;
      expect_eq($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2 == 0));
      expect_eq($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2 == 1));
      expect_eq($sformatf("rr_addr_%0d", i), mem_addr, (i % 2 == 0) ? 16'h0010 : 16'h0020);
      tick();
      expect_eq($sformatf("rr_rvalid0_%0d", i), rvalid0, (i % 2 == 0));
      expect_eq($sformatf("rr_rvalid1_%0d", i), rvalid1, (i % 2 == 1));
      if (i % 2 == 0) expect_eq($sformatf("rr_rdata0_%0d", i), rdata0, 16'h1010);
      else            expect_eq($sformatf("rr_rdata1_%0d", i), rdata1, 16'h1020);
    end
    expect_eq("rr_starve_held", u_rr.r_starve_cnt, 0);

    // Requester 1 writes 0xBEEF, requester 0 reads it back
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = 16'hBEEF;
    #1;
    expect_eq("wr_gnt1", gnt1, 1);
    expect_eq("wr_gnt0", gnt0, 0);
    expect_eq("wr_mem_we", mem_we, 1);
    expect_eq("wr_mem_addr", mem_addr, 16'h0100);
    expect_eq("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
    #1;
    expect_eq("wr_no_rvalid1", rvalid1, 0);
    expect_eq("rd_gnt0", gnt0, 1);
    expect_eq("rd_mem_we", mem_we, 0);
    tick();
    req0 = 1'b0;
    #1;
    expect_eq("rd_rvalid0", rvalid0, 1);
    expect_eq("rd_rdata0", rdata0, 16'hBEEF);
    tick();

    // IO address read, then an immediate re-request coinciding with the response
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd65533;
    #1;
    expect_eq("io_gnt0", gnt0, 1);
    expect_eq("io_mem_addr", mem_addr, 16'd65533);
    tick();
    addr0 = 16'h0010;
    #1;
    expect_eq("io_rvalid0", rvalid0, 1);
    expect_eq("io_rdata0", rdata0, 16'h0005);
    expect_eq("rereq_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0;
    #1;
    expect_eq("rereq_rvalid0", rvalid0, 1);
    expect_eq("rereq_rdata0", rdata0, 16'h1010);
    tick();
    expect_eq("rereq_rvalid0_once", rvalid0, 0);

    // Address 65534 passes through unmodified
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd65534; wdata1 = 16'h0042;
    #1;
    expect_eq("io2_mem_addr", mem_addr, 16'd65534);
    expect_eq("io2_mem_we", mem_we, 1);
    tick();
    req1 = 1'b0; we1 = 1'b0;
    tick();

    // Reset right after an accepted read from requester 1 discards the response
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    #1;
    expect_eq("rst2_acc_gnt1", gnt1, 1);
    tick();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    #1;
    expect_eq("rst2_rvalid1", rvalid1, 0);
    expect_eq("rst2_gnt0", gnt0, 0);
    expect_eq("rst2_gnt1", gnt1, 0);
    expect_eq("rst2_mem_we", mem_we, 0);
    tick();
    expect_eq("rst2_rvalid1_hold", rvalid1, 0);
    tick();
    reset = 1'b1;
    we0 = 1'b0; we1 = 1'b0;
    #1;
    expect_eq("rst2_rel_gnt0", gnt0, 1);
    expect_eq("rst2_rel_gnt1", gnt1, 0);
    tick();
    expect_eq("rst2_rel_rvalid1", rvalid1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Fixed priority with STARVE_LIMIT=3: gnt0 x3, forced gnt1, then gnt0 again
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    for (int c = 1; c <= 5; c++) begin
      #1;
      expect_eq($sformatf("fx_gnt0_c%0d", c), fx_gnt0, (c != 4));
      expect_eq($sformatf("fx_gnt1_c%0d", c), fx_gnt1, (c == 4));
      tick();
      if (c == 3) expect_eq("fx_starve_sat", u_fx.r_starve_cnt, 3);
      if (c == 4) expect_eq("fx_starve_clr", u_fx.r_starve_cnt, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
